// File: rtl/vga_pkg.sv
// Shared types for the VGA write arbiter: command struct, drain FSM states, defaults.
package vga_pkg;

    localparam int FIFO_DEPTH_DEF = 4;
    localparam int ADDR_W_DEF     = 14;
    // Widest image address the command struct carries; ADDR_W must not exceed this.
    localparam int CMD_ADDR_W     = 16;

    typedef struct packed {
        logic                  is_image;
        logic [CMD_ADDR_W-1:0] addr;
        logic [7:0]            data;
    } vga_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_SCROLL
    } drain_st_e;

endpackage

// File: rtl/vga_cmd_fifo.sv
// Synchronous command FIFO; pointers wrap modulo DEPTH, async reset flushes contents.
module vga_cmd_fifo
    import vga_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic                   push,
    input  vga_cmd_t               wdata,
    input  logic                   pop,
    output vga_cmd_t               rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    vga_cmd_t        mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    // Storage is not reset; flushing the pointers and count discards it.
    always_ff @(posedge HCLK) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vga_wr_arbiter.sv
// Two-requester round-robin write arbiter feeding console/image write strobes through a FIFO.
// Optional stall statistics counter enabled by defining VGA_WR_ARB_STATS_EN.
module vga_wr_arbiter
    import vga_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int ADDR_W     = ADDR_W_DEF
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_is_image,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [7:0]        req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_is_image,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [7:0]        req1_data,
    input  logic              scroll,
    output logic              console_we,
    output logic [7:0]        console_wdata,
    output logic              image_we,
    output logic [ADDR_W-1:0] image_addr,
    output logic [7:0]        image_wdata,
    output logic              busy,
    output logic [15:0]       stall_count
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          last1;
    logic          grant0, grant1;
    logic          acc0, acc1, push, pop;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    vga_cmd_t      push_cmd, head;
    drain_st_e     state, state_nxt;
    logic          stall;
    logic          unused_addr_hi;

    // last1 = requester 1 was accepted most recently; reset value favours requester 0.
    assign grant0     = req0_valid & (~req1_valid | last1);
    assign grant1     = req1_valid & (~req0_valid | ~last1);
    assign req0_ready = HRESETn & ~fifo_full & grant0;
    assign req1_ready = HRESETn & ~fifo_full & grant1;
    assign acc0       = req0_ready & req0_valid;
    assign acc1       = req1_ready & req1_valid;
    assign push       = acc0 | acc1;

    always_comb begin
        push_cmd = '0;
        if (acc1) begin
            push_cmd.is_image = req1_is_image;
            push_cmd.addr     = CMD_ADDR_W'(req1_addr);
            push_cmd.data     = req1_data;
        end else begin
            push_cmd.is_image = req0_is_image;
            push_cmd.addr     = CMD_ADDR_W'(req0_addr);
            push_cmd.data     = req0_data;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)  last1 <= 1'b1;
        else if (push) last1 <= acc1;
    end

    vga_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .push    (push),
        .wdata   (push_cmd),
        .pop     (pop),
        .rdata   (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign stall          = ~head.is_image & scroll;
    assign unused_addr_hi = ^(head.addr >> ADDR_W);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Strict in-order drain: a stalled console head blocks everything behind it.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (push) state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (stall) begin
                    state_nxt = ST_WAIT_SCROLL;
                end else begin
                    pop = 1'b1;
                    if (fifo_count == CW'(1) && !push) state_nxt = ST_IDLE;
                end
            end
            ST_WAIT_SCROLL: begin
                if (!scroll) state_nxt = ST_ISSUE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            console_we    <= 1'b0;
            console_wdata <= '0;
            image_we      <= 1'b0;
            image_addr    <= '0;
            image_wdata   <= '0;
        end else begin
            console_we    <= pop & ~head.is_image;
            console_wdata <= (pop & ~head.is_image) ? head.data : 8'h00;
            image_we      <= pop & head.is_image;
            image_addr    <= (pop & head.is_image) ? ADDR_W'(head.addr) : '0;
            image_wdata   <= (pop & head.is_image) ? head.data : 8'h00;
        end
    end

    assign busy = ~fifo_empty | console_we | image_we;

`ifdef VGA_WR_ARB_STATS_EN
    logic [15:0] stall_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            stall_q <= '0;
        else if (state == ST_WAIT_SCROLL && stall_q != 16'hFFFF)
            stall_q <= stall_q + 16'd1;
    end

    assign stall_count = stall_q;
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_vga_wr_arbiter.sv
// Directed bench for vga_wr_arbiter: single write, contention, scroll stall, full, reset mid-drain.
module tb_vga_wr_arbiter;

    localparam int AW = 14;

    logic          HCLK = 1'b0;
    logic          HRESETn = 1'b0;
    logic          req0_valid, req0_ready, req0_is_image;
    logic [AW-1:0] req0_addr;
    logic [7:0]    req0_data;
    logic          req1_valid, req1_ready, req1_is_image;
    logic [AW-1:0] req1_addr;
    logic [7:0]    req1_data;
    logic          scroll;
    logic          console_we, image_we, busy;
    logic [7:0]    console_wdata, image_wdata;
    logic [AW-1:0] image_addr;
    logic [15:0]   stall_count;

    int n_vec = 0;
    int n_err = 0;

    vga_wr_arbiter #(.FIFO_DEPTH(4), .ADDR_W(AW)) dut (
        .HCLK          (HCLK),
        .HRESETn       (HRESETn),
        .req0_valid    (req0_valid),
        .req0_ready    (req0_ready),
        .req0_is_image (req0_is_image),
        .req0_addr     (req0_addr),
        .req0_data     (req0_data),
        .req1_valid    (req1_valid),
        .req1_ready    (req1_ready),
        .req1_is_image (req1_is_image),
        .req1_addr     (req1_addr),
        .req1_data     (req1_data),
        .scroll        (scroll),
        .console_we    (console_we),
        .console_wdata (console_wdata),
        .image_we      (image_we),
        .image_addr    (image_addr),
        .image_wdata   (image_wdata),
        .busy          (busy),
        .stall_count   (stall_count)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req0_is_image = 0; req0_addr = '0; req0_data = '0;
        req1_valid = 0; req1_is_image = 0; req1_addr = '0; req1_data = '0;
        scroll = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        HRESETn = 0;
        step();
        step();
        HRESETn = 1;
    endtask

    // Strobe exclusivity and zeroed payloads, sampled mid-cycle.
    always @(negedge HCLK) begin
        if (HRESETn) begin
            chk("we_exclusive", {31'd0, console_we & image_we}, 32'd0);
            if (!console_we) chk("cwdata_idle", {24'd0, console_wdata}, 32'd0);
            if (!image_we) chk("iaddr_idle", {18'd0, image_addr} | {24'd0, image_wdata}, 32'd0);
        end
    end

    logic [15:0] exp_stall9, exp_stall10;

    initial begin
`ifdef VGA_WR_ARB_STATS_EN
        exp_stall9  = 16'd9;
        exp_stall10 = 16'd10;
`else
        exp_stall9  = 16'd0;
        exp_stall10 = 16'd0;
`endif
        // Reset state: ready low even with valid high
        idle_inputs();
        req0_valid = 1; req1_valid = 1;
        #2;
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cwe", console_we, 0);
        chk("rst_iwe", image_we, 0);
        chk("rst_stall", stall_count, 0);

        // Single image command
        do_reset();
        req0_valid = 1; req0_is_image = 1; req0_addr = 14'h0010; req0_data = 8'hA5;
        #1 chk("single_ready", req0_ready, 1);
        step();
        req0_valid = 0;
        chk("single_busy_q", busy, 1);
        chk("single_iwe_early", image_we, 0);
        step();
        chk("single_iwe", image_we, 1);
        chk("single_addr", image_addr, 14'h0010);
        chk("single_data", image_wdata, 8'hA5);
        chk("single_cwe", console_we, 0);
        step();
        chk("single_iwe_off", image_we, 0);
        chk("single_busy_off", busy, 0);

        // Contention: round-robin alternation
        do_reset();
        req0_valid = 1; req0_is_image = 1; req0_addr = 14'h1; req0_data = 8'h11;
        req1_valid = 1; req1_is_image = 1; req1_addr = 14'h2; req1_data = 8'h22;
        #1 chk("rr0_r0", req0_ready, 1);
        chk("rr0_r1", req1_ready, 0);
        step();
        chk("rr1_r0", req0_ready, 0);
        chk("rr1_r1", req1_ready, 1);
        step();
        chk("rr2_r0", req0_ready, 1);
        chk("rr2_data", image_wdata, 8'h11);
        step();
        chk("rr3_r1", req1_ready, 1);
        chk("rr3_data", image_wdata, 8'h22);
        step();
        req0_valid = 0; req1_valid = 0;
        chk("rr4_data", image_wdata, 8'h11);
        step();
        chk("rr5_data", image_wdata, 8'h22);
        chk("rr5_addr", image_addr, 14'h2);
        step();
        chk("rr6_iwe", image_we, 0);
        chk("rr6_busy", busy, 0);

        // Scroll stall: console head blocks image behind it
        do_reset();
        req0_valid = 1; req0_is_image = 0; req0_data = 8'h41;
        #1 chk("scr_ready_c", req0_ready, 1);
        step();
        scroll = 1;
        req0_is_image = 1; req0_addr = 14'h0123; req0_data = 8'h7E;
        #1 chk("scr_ready_i", req0_ready, 1);
        step();
        req0_valid = 0;
        for (int i = 0; i < 9; i++) begin
            step();
            chk("scr_hold_cwe", console_we, 0);
            chk("scr_hold_iwe", image_we, 0);
        end
        scroll = 0;
        chk("scr_stall9", stall_count, exp_stall9);
        step();
        chk("scr_exit_cwe", console_we, 0);
        chk("scr_stall10", stall_count, exp_stall10);
        step();
        chk("scr_cwe", console_we, 1);
        chk("scr_cdata", console_wdata, 8'h41);
        chk("scr_iwe_off", image_we, 0);
        step();
        chk("scr_iwe", image_we, 1);
        chk("scr_cwe_off", console_we, 0);
        chk("scr_iaddr", image_addr, 14'h0123);
        chk("scr_idata", image_wdata, 8'h7E);
        step();
        chk("scr_busy_off", busy, 0);
        chk("scr_stall_hold", stall_count, exp_stall10);

        // Full: depth 4, fifth command waits for the first pop
        do_reset();
        scroll = 1;
        req0_valid = 1; req0_is_image = 0; req0_data = 8'h50;
        for (int i = 0; i < 4; i++) begin
            #1 chk("full_acc_ready", req0_ready, 1);
            step();
            req0_data = 8'h51 + 8'(i);
        end
        for (int i = 0; i < 3; i++) begin
            #1 chk("full_ready_low", req0_ready, 0);
            chk("full_no_cwe", console_we, 0);
            step();
        end
        scroll = 0;
        #1 chk("full_ready_low2", req0_ready, 0);
        step();
        chk("full_ready_low3", req0_ready, 0);
        chk("full_cwe_wait", console_we, 0);
        step();
        chk("full_cwe0", console_we, 1);
        chk("full_data0", console_wdata, 8'h50);
        chk("full_ready_back", req0_ready, 1);
        step();
        req0_valid = 0;
        chk("full_data1", console_wdata, 8'h51);
        step();
        chk("full_data2", console_wdata, 8'h52);
        step();
        chk("full_data3", console_wdata, 8'h53);
        step();
        chk("full_data4", console_wdata, 8'h54);
        step();
        chk("full_cwe_off", console_we, 0);
        chk("full_busy_off", busy, 0);

        // Reset mid-drain
        do_reset();
        scroll = 1;
        req1_valid = 1; req1_is_image = 0; req1_data = 8'h31;
        for (int i = 0; i < 3; i++) begin
            #1 chk("md_ready1", req1_ready, 1);
            step();
            req1_data = req1_data + 8'd1;
        end
        req1_valid = 0; scroll = 0;
        step();
        chk("md_cwe_wait", console_we, 0);
        step();
        chk("md_cwe", console_we, 1);
        chk("md_cdata", console_wdata, 8'h31);
        HRESETn = 0;
        req0_valid = 1; req1_valid = 1;
        #1 chk("md_rst_cwe", console_we, 0);
        chk("md_rst_busy", busy, 0);
        chk("md_rst_r0", req0_ready, 0);
        chk("md_rst_r1", req1_ready, 0);
        req0_valid = 0; req1_valid = 0;
        step();
        HRESETn = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("md_post_cwe", console_we, 0);
            chk("md_post_busy", busy, 0);
        end
        req0_valid = 1; req0_is_image = 1; req0_addr = 14'h5; req0_data = 8'h60;
        req1_valid = 1; req1_is_image = 1; req1_addr = 14'h6; req1_data = 8'h61;
        #1 chk("md_fav_r0", req0_ready, 1);
        chk("md_fav_r1", req1_ready, 0);
        step();
        req0_valid = 0; req1_valid = 0;
        step();
        chk("md_fav_iwe", image_we, 1);
        chk("md_fav_data", image_wdata, 8'h60);
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
